// File: rtl/alu_issue.sv
// alu_issue: single-issue decode/issue unit for RV32I OP and OP-IMM.
// Decodes one instruction at a time, reads operands from a 32x32 register
// file, drives a registered ALU, waits out its latency and writes back.
module alu_issue #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    output logic [31:0] alu_rs1_o,
    output logic [31:0] alu_rs2_o,
    output logic [2:0]  alu_funct3_o,
    output logic        alu_funct7_o,
    input  logic [31:0] alu_rd_i,
    input  logic        alu_z_i,
    output logic        retire_valid_o,
    output logic [4:0]  retire_rd_addr_o,
    output logic [31:0] retire_data_o,
    output logic        retire_z_o,
    output logic        illegal_o,
    input  logic [4:0]  dbg_addr_i,
    output logic [31:0] dbg_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // EXEC lasts ALU_LATENCY cycles, so the counter starts one below it.
    localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [4:0]  rd_q;
    logic [31:0] regs_q [32];

    logic [31:0] alu_rs1_q;
    logic [31:0] alu_rs2_q;
    logic [2:0]  alu_funct3_q;
    logic        alu_funct7_q;
    logic        retire_valid_q;
    logic [4:0]  retire_rd_addr_q;
    logic [31:0] retire_data_q;
    logic        retire_z_q;
    logic        illegal_q;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        legal_s;
    logic [31:0] op_b_s;
    logic        f7_sel_s;

    assign opcode_s = instr_i[6:0];
    assign funct3_s = instr_i[14:12];
    assign funct7_s = instr_i[31:25];

    // Decode legality, operand B source and the SUB/SRA select bit.
    always_comb begin
        legal_s  = 1'b0;
        op_b_s   = 32'd0;
        f7_sel_s = 1'b0;
        case (opcode_s)
            7'b0110011: begin
                op_b_s   = regs_q[instr_i[24:20]];
                f7_sel_s = instr_i[30];
                legal_s  = (funct7_s == 7'b0000000) ||
                           ((funct7_s == 7'b0100000) &&
                            ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
            end
            7'b0010011: begin
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    op_b_s   = {27'd0, instr_i[24:20]};
                    f7_sel_s = instr_i[30];
                    legal_s  = (funct7_s == 7'b0000000) ||
                               ((funct7_s == 7'b0100000) && (funct3_s == 3'b101));
                end else begin
                    op_b_s   = {{20{instr_i[31]}}, instr_i[31:20]};
                    f7_sel_s = 1'b0;
                    legal_s  = 1'b1;
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // Issue FSM: accept/decode in IDLE, count ALU latency, capture result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= IDLE;
            cnt_q            <= 3'd0;
            rd_q             <= 5'd0;
            alu_rs1_q        <= 32'd0;
            alu_rs2_q        <= 32'd0;
            alu_funct3_q     <= 3'd0;
            alu_funct7_q     <= 1'b0;
            retire_valid_q   <= 1'b0;
            retire_rd_addr_q <= 5'd0;
            retire_data_q    <= 32'd0;
            retire_z_q       <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            retire_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid_i && legal_s) begin
                        alu_rs1_q    <= regs_q[instr_i[19:15]];
                        alu_rs2_q    <= op_b_s;
                        alu_funct3_q <= funct3_s;
                        alu_funct7_q <= f7_sel_s;
                        rd_q         <= instr_i[11:7];
                        cnt_q        <= CNT_INIT;
                        state_q      <= EXEC;
                    end else if (instr_valid_i) begin
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= WB;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                WB: begin
                    retire_valid_q   <= 1'b1;
                    retire_rd_addr_q <= rd_q;
                    retire_data_q    <= alu_rd_i;
                    retire_z_q       <= alu_z_i;
                    state_q          <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register file: cleared on reset, written at the write-back edge; x0 stays 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if ((state_q == WB) && (rd_q != 5'd0)) begin
            regs_q[rd_q] <= alu_rd_i;
        end else begin
            regs_q[0] <= 32'd0;
        end
    end

    assign instr_ready_o    = (state_q == IDLE);
    assign alu_rs1_o        = alu_rs1_q;
    assign alu_rs2_o        = alu_rs2_q;
    assign alu_funct3_o     = alu_funct3_q;
    assign alu_funct7_o     = alu_funct7_q;
    assign retire_valid_o   = retire_valid_q;
    assign retire_rd_addr_o = retire_rd_addr_q;
    assign retire_data_o    = retire_data_q;
    assign retire_z_o       = retire_z_q;
    assign illegal_o        = illegal_q;
    assign dbg_data_o       = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural pipelined ALU stub.
module tb_alu_issue;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] alu_rs1, alu_rs2;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_rd;
    logic        alu_z;
    logic        retire_valid;
    logic [4:0]  retire_rd_addr;
    logic [31:0] retire_data;
    logic        retire_z;
    logic        illegal;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_rs1, cap_rs2, cap_data;
    logic [2:0]  cap_f3;
    logic        cap_f7, cap_z;
    logic [4:0]  cap_rd;

    alu_issue #(.ALU_LATENCY(LAT)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .instr_valid_i    (instr_valid),
        .instr_ready_o    (instr_ready),
        .instr_i          (instr),
        .alu_rs1_o        (alu_rs1),
        .alu_rs2_o        (alu_rs2),
        .alu_funct3_o     (alu_funct3),
        .alu_funct7_o     (alu_funct7),
        .alu_rd_i         (alu_rd),
        .alu_z_i          (alu_z),
        .retire_valid_o   (retire_valid),
        .retire_rd_addr_o (retire_rd_addr),
        .retire_data_o    (retire_data),
        .retire_z_o       (retire_z),
        .illegal_o        (illegal),
        .dbg_addr_i       (dbg_addr),
        .dbg_data_o       (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU stub: registered, LAT stages deep
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic f7);
        logic [31:0] r;
        case (f3)
            3'd0: r = f7 ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {(r == 32'd0), r};
    endfunction

    logic [32:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_rd = pipe[LAT-1][31:0];
    assign alu_z  = pipe[LAT-1][32];

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Issue one instruction, capture ALU inputs and the retire record,
    // and check that retire arrives LAT+1 edges after accept.
    task automatic issue(input logic [31:0] ins);
        int  n;
        bit  seen;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        cap_rs1 = alu_rs1; cap_rs2 = alu_rs2; cap_f3 = alu_funct3; cap_f7 = alu_funct7;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (retire_valid === 1'b1) seen = 1'b1;
        end
        cap_rd = retire_rd_addr; cap_data = retire_data; cap_z = retire_z;
        checks++;
        if (!seen || n != LAT + 1) begin
            errors++;
            $display("FAIL retire_latency instr=%h: got %0d edges (seen=%0d), want %0d", ins, n, seen, LAT + 1);
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_retire instr=%h: got %b want 1", ins, instr_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || alu_rs1 !== 32'd0 || alu_rs2 !== 32'd0 ||
            alu_funct3 !== 3'd0 || alu_funct7 !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu: ready=%b rs1=%h rs2=%h f3=%h f7=%b want 1/0/0/0/0",
                     instr_ready, alu_rs1, alu_rs2, alu_funct3, alu_funct7);
        end
        checks++;
        if (retire_valid !== 1'b0 || retire_rd_addr !== 5'd0 || retire_data !== 32'd0 ||
            retire_z !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_retire: v=%b rd=%h d=%h z=%b ill=%b want all 0",
                     retire_valid, retire_rd_addr, retire_data, retire_z, illegal);
        end
        rst_n = 1'b1;
        @(negedge clk);
        dbg_addr = 5'd5;
        #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: x5=%h want 0", dbg_data);
        end
    endtask

    task automatic test_add_chain;
        issue(enc_i(12'd20, 5'd0, 3'd0, 5'd1));
        issue(enc_i(12'd30, 5'd0, 3'd0, 5'd2));
        issue(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
        checks++;
        if (cap_rs1 !== 32'd20 || cap_rs2 !== 32'd30) begin
            errors++;
            $display("FAIL add_operands: rs1=%h rs2=%h want 14/1e", cap_rs1, cap_rs2);
        end
        dbg_addr = 5'd3;
        #1;
        checks++;
        if (dbg_data !== 32'd50 || cap_rd !== 5'd3 || cap_data !== 32'd50) begin
            errors++;
            $display("FAIL add_result: x3=%h rd=%0d data=%h want 32/3/32", dbg_data, cap_rd, cap_data);
        end
    endtask

    task automatic test_illegal;
        bit got_retire;
        got_retire = 1'b0;
        @(negedge clk);
        instr = 32'h0000_0073;
        instr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (illegal !== 1'b1 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_system: illegal=%b ready=%b want 1/1", illegal, instr_ready);
        end
        if (retire_valid === 1'b1) got_retire = 1'b1;
        instr = 32'h4000_E033;
        @(negedge clk);
        checks++;
        if (illegal !== 1'b1 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_funct: illegal=%b ready=%b want 1/1", illegal, instr_ready);
        end
        if (retire_valid === 1'b1) got_retire = 1'b1;
        instr_valid = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (retire_valid === 1'b1) got_retire = 1'b1;
        end
        checks++;
        if (got_retire || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_no_retire: retire_seen=%b illegal=%b want 0/0", got_retire, illegal);
        end
        dbg_addr = 5'd3;
        #1;
        checks++;
        if (dbg_data !== 32'd50 || alu_rs2 !== 32'd30 || alu_funct3 !== 3'd0) begin
            errors++;
            $display("FAIL illegal_no_change: x3=%h rs2=%h f3=%h want 32/1e/0", dbg_data, alu_rs2, alu_funct3);
        end
    endtask

    task automatic test_sub;
        issue(enc_i(12'd8, 5'd0, 3'd0, 5'd1));
        issue(enc_i(12'd3, 5'd0, 3'd0, 5'd2));
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
        dbg_addr = 5'd4;
        #1;
        checks++;
        if (cap_f3 !== 3'd0 || cap_f7 !== 1'b1 || dbg_data !== 32'd5 || cap_z !== 1'b0) begin
            errors++;
            $display("FAIL sub_nonzero: f3=%h f7=%b x4=%h z=%b want 0/1/5/0", cap_f3, cap_f7, dbg_data, cap_z);
        end
        issue(enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd5));
        checks++;
        if (cap_z !== 1'b1 || cap_data !== 32'd0 || cap_rd !== 5'd5) begin
            errors++;
            $display("FAIL sub_zero: z=%b data=%h rd=%0d want 1/0/5", cap_z, cap_data, cap_rd);
        end
    endtask

    task automatic test_shift;
        issue(enc_i(12'd1, 5'd0, 3'd0, 5'd6));
        issue(enc_i(12'd31, 5'd6, 3'd1, 5'd6));
        dbg_addr = 5'd6;
        #1;
        checks++;
        if (dbg_data !== 32'h8000_0000) begin
            errors++;
            $display("FAIL slli: x6=%h want 80000000", dbg_data);
        end
        issue(enc_i(12'h403, 5'd6, 3'd5, 5'd7));
        dbg_addr = 5'd7;
        #1;
        checks++;
        if (cap_rs2 !== 32'd3 || cap_f7 !== 1'b1 || dbg_data !== 32'hF000_0000) begin
            errors++;
            $display("FAIL srai: rs2=%h f7=%b x7=%h want 3/1/f0000000", cap_rs2, cap_f7, dbg_data);
        end
        issue(enc_i(12'h003, 5'd6, 3'd5, 5'd8));
        dbg_addr = 5'd8;
        #1;
        checks++;
        if (cap_f7 !== 1'b0 || dbg_data !== 32'h1000_0000) begin
            errors++;
            $display("FAIL srli: f7=%b x8=%h want 0/10000000", cap_f7, dbg_data);
        end
    endtask

    task automatic test_x0;
        issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd9));
        dbg_addr = 5'd9;
        #1;
        checks++;
        if (dbg_data !== 32'hFFFF_FFFF || cap_rs2 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL addi_neg: x9=%h rs2=%h want ffffffff/ffffffff", dbg_data, cap_rs2);
        end
        issue(enc_r(7'd0, 5'd9, 5'd9, 3'd0, 5'd0));
        dbg_addr = 5'd0;
        #1;
        checks++;
        if (cap_rd !== 5'd0 || cap_data !== 32'hFFFF_FFFE || dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL write_x0: rd=%0d data=%h x0=%h want 0/fffffffe/0", cap_rd, cap_data, dbg_data);
        end
    endtask

    // Hold valid high: only one accept per LAT+2 cycles, dependent reads updated
    task automatic test_back_to_back;
        int nret;
        nret = 0;
        @(negedge clk);
        instr = enc_i(12'd1, 5'd11, 3'd0, 5'd11);
        instr_valid = 1'b1;
        repeat (2 * (LAT + 2)) begin
            @(posedge clk);
            @(negedge clk);
            if (retire_valid === 1'b1) nret++;
        end
        instr_valid = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (retire_valid === 1'b1) nret++;
        end
        dbg_addr = 5'd11;
        #1;
        checks++;
        if (nret != 2 || dbg_data !== 32'd2) begin
            errors++;
            $display("FAIL back_to_back: retires=%0d x11=%h want 2/2", nret, dbg_data);
        end
    endtask

    task automatic test_reset_mid_exec;
        bit got_retire;
        got_retire = 1'b0;
        @(negedge clk);
        instr = enc_i(12'd5, 5'd0, 3'd0, 5'd10);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL exec_not_ready: ready=%b want 0", instr_ready);
        end
        rst_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || alu_rs2 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b rs2=%h want 1/0", instr_ready, alu_rs2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (retire_valid === 1'b1) got_retire = 1'b1;
        end
        dbg_addr = 5'd10;
        #1;
        checks++;
        if (got_retire || dbg_data !== 32'd0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: retire_seen=%b x10=%h ready=%b want 0/0/1", got_retire, dbg_data, instr_ready);
        end
        dbg_addr = 5'd3;
        #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_clears_regs: x3=%h want 0", dbg_data);
        end
    endtask

    initial begin
        test_reset();
        test_add_chain();
        test_illegal();
        test_sub();
        test_shift();
        test_x0();
        test_back_to_back();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
